hazard_stall_unit: RTL
======================

Name: hazard_stall_unit

Overview:
- Producer-side counterpart of the ID-stage forwarding logic in the 5-stage pipeline (IF/ID/EXE/MEM/WB).
- Decides when forwarding cannot cover a dependency and handles the consequence:
  - stalls IF/ID and inserts an ID/EXE bubble on RAW hazards;
  - flushes on taken branches;
  - freezes the whole pipeline while the MEM-stage SRAM access is pending, with a timeout watchdog.
- Also keeps a saturating stall-cycle counter for performance debug.

Parameters:
REG_W, 5, register index width
TIMEOUT, 64, max consecutive SRAM wait cycles before fatal error (>=2)
CNT_W, 32, stall counter width

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable_forward  input  1  1 = forwarding unit active
src1  input  REG_W  ID-stage first source register
use_src1  input  1  ID instruction reads src1
src2  input  REG_W  ID-stage second source register
two_regs  input  1  ID instruction reads src2
exe_dest  input  REG_W  ID/EXE destination
exe_wb_en  input  1  EXE instruction writes back
exe_mem_read  input  1  EXE instruction is a load
mem_dest  input  REG_W  EXE/MEM destination
mem_wb_en  input  1  MEM instruction writes back
mem_req  input  1  MEM stage performing load/store this cycle
sram_ready  input  1  SRAM controller completes access this cycle
branch_taken  input  1  EXE resolved a taken branch
pc_freeze  output  1  hold PC
ifid_freeze  output  1  hold IF/ID register
ifid_flush  output  1  clear IF/ID to NOP
idexe_bubble  output  1  load NOP into ID/EXE
back_freeze  output  1  hold ID/EXE, EXE/MEM, MEM/WB registers
mem_timeout  output  1  sticky fatal SRAM timeout flag
stall_cycles  output  CNT_W  saturating count of cycles with pc_freeze=1
state  output  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 ERR

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN, wait counter=0, mem_timeout=0, stall_cycles=0.
  - All control outputs are 0 while state=RUN and inputs are idle.
- Hazard terms (combinational; register 0 is not special):
  - raw_exe = exe_wb_en & ((use_src1 & src1==exe_dest) | (two_regs & src2==exe_dest))
  - raw_mem: same form using mem_wb_en and mem_dest.
  - data_hz = enable_forward ? (raw_exe & exe_mem_read) : (raw_exe | raw_mem)
- mem_stall = (state==RUN & mem_req & ~sram_ready) | state==MEM_WAIT & ~sram_ready | state==ERR.
- Output priority, all combinational, same cycle:
  1. mem_stall: pc_freeze = ifid_freeze = back_freeze = 1; ifid_flush = idexe_bubble = 0. Branch and data hazards are ignored (EXE is frozen, so they are re-evaluated later).
  2. branch_taken: ifid_flush = idexe_bubble = 1; no freeze. Branch overrides data_hz.
  3. data_hz: pc_freeze = ifid_freeze = idexe_bubble = 1; back_freeze = 0.
  4. Otherwise all 0.
- Load-use with forwarding costs exactly 1 bubble: next cycle the load is in MEM and raw_exe clears.
- FSM:
  - RUN -> MEM_WAIT when mem_req & ~sram_ready; wait counter := 1.
  - MEM_WAIT, sram_ready=1 -> RUN; freeze drops that same cycle so WB captures the data.
  - MEM_WAIT, ~sram_ready: counter += 1; when counter == TIMEOUT-1 -> ERR.
  - ERR: mem_timeout=1, full freeze; exits only on reset.
  - sram_ready in the same cycle mem_req rises: no wait, stay in RUN.
- stall_cycles increments each cycle pc_freeze=1 and saturates at all-ones.
- Reset mid-wait returns to RUN immediately; counters clear.

Decomposition:
- Shared package pipe_pkg:
  - FSM state encoding (ST_RUN, ST_MEM_WAIT, ST_ERR);
  - REG_W constant;
  - NOP/bubble encoding constants used by pipeline registers.
- One natural sub-module: sat_counter (parameterised width, enable, async active-low clear), used for both the wait counter and stall_cycles.

Test Plan:
- Forwarding on: EXE load to r3, ID reads src1=r3 -> pc_freeze = ifid_freeze = idexe_bubble = 1 for exactly 1 cycle; stall_cycles=1.
- Forwarding off: MEM writes r5 (mem_wb_en=1), ID two_regs=1, src2=r5 -> bubble asserted. Same stimulus with two_regs=0 -> no stall.
- mem_req=1, sram_ready low for 5 cycles then high:
  - state=MEM_WAIT; back_freeze=1 for 5 cycles, 0 on the ready cycle;
  - state=RUN afterwards; stall_cycles=5.
- Branch_taken and load-use hazard in the same cycle -> ifid_flush = idexe_bubble = 1, pc_freeze=0.
- TIMEOUT=4 with sram_ready held 0 -> state=ERR after cycle 4 and mem_timeout=1 sticky; rst_n low -> all outputs 0, state=RUN.
- Branch_taken during MEM_WAIT -> flush suppressed and freeze held. After ready, with branch_taken still high -> flush asserted.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: FSM state encoding, register index width and
// the control-word encodings driven into the pipeline registers.
package pipe_pkg;

   localparam int unsigned DEF_REG_W = 5;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERR      = 2'd2
   } state_e;

   typedef struct packed {
      logic pc_freeze;
      logic ifid_freeze;
      logic ifid_flush;
      logic idexe_bubble;
      logic back_freeze;
   } ctrl_t;

   // NOP control word: no freeze, no flush, no bubble
   localparam ctrl_t CTRL_NOP = '{pc_freeze: 1'b0, ifid_freeze: 1'b0, ifid_flush: 1'b0,
                                  idexe_bubble: 1'b0, back_freeze: 1'b0};
   localparam ctrl_t CTRL_MEM_FREEZE = '{pc_freeze: 1'b1, ifid_freeze: 1'b1, ifid_flush: 1'b0,
                                         idexe_bubble: 1'b0, back_freeze: 1'b1};
   localparam ctrl_t CTRL_FLUSH = '{pc_freeze: 1'b0, ifid_freeze: 1'b0, ifid_flush: 1'b1,
                                    idexe_bubble: 1'b1, back_freeze: 1'b0};
   localparam ctrl_t CTRL_DATA_STALL = '{pc_freeze: 1'b1, ifid_freeze: 1'b1, ifid_flush: 1'b0,
                                         idexe_bubble: 1'b1, back_freeze: 1'b0};

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Hazard/stall control bundle between the pipeline datapath (master) and the
// hazard stall unit (slave).
interface hazard_stall_unit_if
   import pipe_pkg::*;
#(
   parameter int unsigned REG_W = DEF_REG_W,
   parameter int unsigned CNT_W = 32
);
   logic             enable_forward;
   logic [REG_W-1:0] src1;
   logic             use_src1;
   logic [REG_W-1:0] src2;
   logic             two_regs;
   logic [REG_W-1:0] exe_dest;
   logic             exe_wb_en;
   logic             exe_mem_read;
   logic [REG_W-1:0] mem_dest;
   logic             mem_wb_en;
   logic             mem_req;
   logic             sram_ready;
   logic             branch_taken;

   logic             pc_freeze;
   logic             ifid_freeze;
   logic             ifid_flush;
   logic             idexe_bubble;
   logic             back_freeze;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cycles;
   logic [1:0]       state;

   modport master (
      output enable_forward, src1, use_src1, src2, two_regs,
             exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
             mem_req, sram_ready, branch_taken,
      input  pc_freeze, ifid_freeze, ifid_flush, idexe_bubble, back_freeze,
             mem_timeout, stall_cycles, state
   );

   modport slave (
      input  enable_forward, src1, use_src1, src2, two_regs,
             exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
             mem_req, sram_ready, branch_taken,
      output pc_freeze, ifid_freeze, ifid_flush, idexe_bubble, back_freeze,
             mem_timeout, stall_cycles, state
   );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_count
);
   logic [W-1:0] r_count;

   // clear wins over increment; holds at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en && (r_count != {W{1'b1}})) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count = r_count;
endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall control: RAW load-use bubbles, branch flush and full
// freeze during MEM-stage SRAM waits with a timeout watchdog.
module hazard_stall_unit
   import pipe_pkg::*;
#(
   parameter int unsigned REG_W   = DEF_REG_W,
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 32
) (
   input logic                clk,
   input logic                rst_n,
   hazard_stall_unit_if.slave bus
);
   localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

   state_e             r_state;
   state_e             w_next_state;
   ctrl_t              w_ctrl;
   logic               w_mem_stall;
   logic               w_wait_inc;
   logic               w_wait_clr;
   logic [WAIT_W-1:0]  w_wait_cnt;
   logic [CNT_W-1:0]   w_stall_cnt;

   logic [REG_W-1:0]   w_src1;
   logic [REG_W-1:0]   w_src2;
   logic [REG_W-1:0]   w_exe_dest;
   logic [REG_W-1:0]   w_mem_dest;
   logic               w_raw_exe;
   logic               w_raw_mem;
   logic               w_data_hz;

   assign w_src1     = bus.src1;
   assign w_src2     = bus.src2;
   assign w_exe_dest = bus.exe_dest;
   assign w_mem_dest = bus.mem_dest;

   // register 0 is treated like any other register
   assign w_raw_exe = bus.exe_wb_en & ((bus.use_src1 & (w_src1 == w_exe_dest)) |
                                       (bus.two_regs & (w_src2 == w_exe_dest)));
   assign w_raw_mem = bus.mem_wb_en & ((bus.use_src1 & (w_src1 == w_mem_dest)) |
                                       (bus.two_regs & (w_src2 == w_mem_dest)));
   assign w_data_hz = bus.enable_forward ? (w_raw_exe & bus.exe_mem_read)
                                         : (w_raw_exe | w_raw_mem);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_next_state;
      end
   end

   // next state, wait-counter control and prioritised control word
   always_comb begin
      w_next_state = r_state;
      w_ctrl       = CTRL_NOP;
      w_mem_stall  = 1'b0;
      w_wait_inc   = 1'b0;
      w_wait_clr   = 1'b0;

      case (r_state)
         ST_RUN: begin
            if (bus.mem_req && !bus.sram_ready) begin
               w_next_state = ST_MEM_WAIT;
               w_wait_inc   = 1'b1;
               w_mem_stall  = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (bus.sram_ready) begin
               w_next_state = ST_RUN;
               w_wait_clr   = 1'b1;
            end else begin
               w_mem_stall = 1'b1;
               if (w_wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                  w_next_state = ST_ERR;
               end else begin
                  w_wait_inc = 1'b1;
               end
            end
         end
         ST_ERR: begin
            w_mem_stall = 1'b1;
         end
         default: begin
            w_next_state = ST_RUN;
         end
      endcase

      // a frozen EXE re-evaluates branch and data hazards once released
      if (w_mem_stall) begin
         w_ctrl = CTRL_MEM_FREEZE;
      end else if (bus.branch_taken) begin
         w_ctrl = CTRL_FLUSH;
      end else if (w_data_hz) begin
         w_ctrl = CTRL_DATA_STALL;
      end
   end

   sat_counter #(.W(WAIT_W)) u_wait_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (w_wait_clr),
      .i_en    (w_wait_inc),
      .o_count (w_wait_cnt)
   );

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (1'b0),
      .i_en    (w_ctrl.pc_freeze),
      .o_count (w_stall_cnt)
   );

   assign bus.pc_freeze    = w_ctrl.pc_freeze;
   assign bus.ifid_freeze  = w_ctrl.ifid_freeze;
   assign bus.ifid_flush   = w_ctrl.ifid_flush;
   assign bus.idexe_bubble = w_ctrl.idexe_bubble;
   assign bus.back_freeze  = w_ctrl.back_freeze;
   assign bus.mem_timeout  = (r_state == ST_ERR);
   assign bus.stall_cycles = w_stall_cnt;
   assign bus.state        = r_state;
endmodule
